// File: rtl/writeback_queue.sv
// Write-back queue: round-robin merges ALU and load results into an in-order FIFO,
// retires one entry per cycle to the register-file write port, and forwards pending values to decode.
module writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_W-1:0]        ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     rf_stall,
    output logic                     rf_write_enable,
    output logic [ADDR_W-1:0]        rf_write_addr,
    output logic [DATA_W-1:0]        rf_write_data,
    input  logic [ADDR_W-1:0]        fwd_addr1,
    input  logic [ADDR_W-1:0]        fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   pending_count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addrMem_q [DEPTH];
    logic [DATA_W-1:0] dataMem_q [DEPTH];

    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              lastGrantLd_q, lastGrantLd_d;
    logic              wbEn_q, wbEn_d;
    logic [ADDR_W-1:0] wbAddr_q, wbAddr_d;
    logic [DATA_W-1:0] wbData_q, wbData_d;

    logic              full;
    logic              aluHs, ldHs;
    logic              push, pop;
    logic [ADDR_W-1:0] pushRd;
    logic [DATA_W-1:0] pushData;

    // On a tie the source that lost last time wins; a lone valid source always wins.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign alu_ready = !full && alu_valid && (!ld_valid || lastGrantLd_q);
    assign ld_ready  = !full && ld_valid && (!alu_valid || !lastGrantLd_q);

    assign aluHs    = alu_valid && alu_ready;
    assign ldHs     = ld_valid && ld_ready;
    assign pushRd   = aluHs ? alu_rd : ld_rd;
    assign pushData = aluHs ? alu_data : ld_data;
    assign push     = (aluHs || ldHs) && (pushRd != '0);
    assign pop      = (count_q != '0) && !rf_stall;

    always_comb begin
        rdPtr_d       = rdPtr_q;
        wrPtr_d       = wrPtr_q;
        lastGrantLd_d = lastGrantLd_q;
        wbEn_d        = 1'b0;
        wbAddr_d      = wbAddr_q;
        wbData_d      = wbData_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

        if (pop) begin
            rdPtr_d  = rdPtr_q + PTR_W'(1);
            wbEn_d   = 1'b1;
            wbAddr_d = addrMem_q[rdPtr_q];
            wbData_d = dataMem_q[rdPtr_q];
        end
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (ldHs) begin
            lastGrantLd_d = 1'b1;
        end else if (aluHs) begin
            lastGrantLd_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            count_q       <= '0;
            lastGrantLd_q <= 1'b1;
            wbEn_q        <= 1'b0;
            wbAddr_q      <= '0;
            wbData_q      <= '0;
        end else begin
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            count_q       <= count_d;
            lastGrantLd_q <= lastGrantLd_d;
            wbEn_q        <= wbEn_d;
            wbAddr_q      <= wbAddr_d;
            wbData_q      <= wbData_d;
        end
    end

    // Storage needs no reset: only slots inside the occupancy window are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem_q[wrPtr_q] <= pushRd;
            dataMem_q[wrPtr_q] <= pushData;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest.
    function automatic logic [DATA_W:0] fwdLookup(input logic [ADDR_W-1:0] addr);
        logic             hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if (wbEn_q && (wbAddr_q == addr)) begin
            hit  = 1'b1;
            data = wbData_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addrMem_q[idx] == addr)) begin
                hit  = 1'b1;
                data = dataMem_q[idx];
            end
        end
        if (addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    assign {fwd_hit1, fwd_data1} = fwdLookup(fwd_addr1);
    assign {fwd_hit2, fwd_data2} = fwdLookup(fwd_addr2);

    assign rf_write_enable = wbEn_q;
    assign rf_write_addr   = wbAddr_q;
    assign rf_write_data   = wbData_q;
    assign pending_count   = count_q;
    assign empty           = (count_q == '0) && !wbEn_q;

endmodule
